shift_sub_div: RTL and testbench

- Sequential restoring (shift-subtract) divider, one quotient bit per clock. It is the inverse of shift_add_mult.
- A 2*WIDTH-bit dividend (a multiplier product) divided by a WIDTH-bit divisor yields a WIDTH-bit quotient and a WIDTH-bit remainder.
- Uses the same start/done handshake as the multiplier, so the two blocks can be chained in datapaths and benches for round-trip checks.

---
 rtl/shift_sub_div.sv | 126 ++++++++++++
 tb/tb_shift_sub_div.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sub_div.sv
// Restoring shift-subtract divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, start/done handshake shared with shift_add_mult.
//
// state | meaning
// IDLE  | after reset, waiting for a start rising edge
// CALC  | shifting/subtracting, one quotient bit per clock
// DONE  | result (or overflow) held until the next launch
module shift_sub_div #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [2*WIDTH-1:0]   i_dividend,
    input  logic [WIDTH-1:0]     i_divisor,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [WIDTH-1:0]     o_quotient,
    output logic [WIDTH-1:0]     o_remainder,
    output logic                 o_overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_start_d;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;
    logic             r_ovf;

    logic             w_launch;
    logic             w_ovf_req;
    logic             w_last;
    logic [WIDTH:0]   w_t;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_launch  = i_start && !r_start_d && (r_state != CALC);
    // High half not below the divisor means the quotient needs more than WIDTH bits
    // (a zero divisor always lands here too).
    assign w_ovf_req = i_dividend[2*WIDTH-1:WIDTH] >= i_divisor;
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    assign w_t       = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_t >= {1'b0, r_div});
    // Partial remainder stays below the divisor, so the subtraction fits in WIDTH bits.
    assign w_rem_nxt = w_ge ? (w_t[WIDTH-1:0] - r_div) : w_t[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= i_start;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_launch) begin
                    w_state_nxt = w_ovf_req ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_q_out <= '0;
            r_r_out <= '0;
            r_ovf   <= 1'b0;
        end else if (w_launch) begin
            r_div <= i_divisor;
            r_ovf <= w_ovf_req;
            if (w_ovf_req) begin
                r_q_out <= '1;
                r_r_out <= '0;
            end else begin
                r_rem <= i_dividend[2*WIDTH-1:WIDTH];
                r_quo <= i_dividend[WIDTH-1:0];
                r_cnt <= '0;
            end
        end else if (r_state == CALC) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_q_out <= w_quo_nxt;
                r_r_out <= w_rem_nxt;
            end
        end
    end

    assign o_busy      = (r_state == CALC);
    assign o_done      = (r_state == DONE);
    assign o_quotient  = r_q_out;
    assign o_remainder = r_r_out;
    assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_shift_sub_div.sv
// Bench for shift_sub_div: directed vector table, multi-cycle corner sequences
// and randomized operands checked against plain integer division.
module tb_shift_sub_div;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           overflow;

    int total = 0;
    int bad   = 0;

    shift_sub_div #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_dividend  (dividend),
        .i_divisor   (divisor),
        .o_busy      (busy),
        .o_done      (done),
        .o_quotient  (quotient),
        .o_remainder (remainder),
        .o_overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer division with the overflow rule on the high half.
    task automatic ref_div(input logic [15:0] dd, input logic [7:0] dv,
                           output logic [7:0] q, output logic [7:0] r,
                           output logic ovf, output int lat);
        int hi;
        hi = int'(dd) / 256;
        if (dv == 0 || hi >= int'(dv)) begin
            q = 8'hFF; r = 8'h00; ovf = 1'b1; lat = 1;
        end else begin
            q = 8'(int'(dd) / int'(dv));
            r = 8'(int'(dd) % int'(dv));
            ovf = 1'b0; lat = 9;
        end
    endtask

    // Called at a negedge; raises start, counts edges until done, leaves start low.
    task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic ovf, output int lat, output int bcnt);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        lat  = 0;
        bcnt = 0;
        while (lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
        q   = quotient;
        r   = remainder;
        ovf = overflow;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t        vecs[7];
    logic [7:0]  q, r, eq, er;
    logic        ovf, eovf;
    int          lat, elat, bcnt;

    initial begin
        vecs[0] = '{16'd49,    8'd7,   8'd7,   8'd0,   1'b0, 9};
        vecs[1] = '{16'd1000,  8'd7,   8'd142, 8'd6,   1'b0, 9};
        vecs[2] = '{16'd16383, 8'd255, 8'd64,  8'd63,  1'b0, 9};
        vecs[3] = '{16'd65024, 8'd255, 8'd254, 8'd254, 1'b0, 9};
        vecs[4] = '{16'h0700,  8'd7,   8'hFF,  8'd0,   1'b1, 1};
        vecs[5] = '{16'd5,     8'd0,   8'hFF,  8'd0,   1'b1, 1};
        vecs[6] = '{16'd100,   8'd3,   8'd33,  8'd1,   1'b0, 9};

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_q", quotient, 0);
        chk("reset_r", remainder, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Held start: one launch, done stays, no relaunch while level remains high.
        dividend = 16'd49; divisor = 8'd7; start = 1'b1;
        lat = 0; bcnt = 0;
        while (lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
        chk("held_lat", lat, 9);
        chk("held_busy_cycles", bcnt, 8);
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            chk("held_no_relaunch_done", done, 1);
            chk("held_no_relaunch_busy", busy, 0);
        end
        chk("held_q", quotient, 7);
        chk("held_r", remainder, 0);
        start = 1'b0;
        @(posedge clk); @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].dd, vecs[i].dv, q, r, ovf, lat, bcnt);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].r);
            chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_busy", i), bcnt, vecs[i].ovf ? 0 : 8);
        end

        // Relaunch from DONE: done must drop right after the launch edge.
        dividend = 16'd100; divisor = 8'd3; start = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("relaunch_done_drop", done, 0);
        chk("relaunch_busy", busy, 1);
        lat = 1;
        while (lat < 40 && !done) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk("relaunch_lat", lat, 9);
        chk("relaunch_q", quotient, 33);
        chk("relaunch_r", remainder, 1);
        start = 1'b0;
        @(posedge clk); @(negedge clk);

        // Operand changes and start toggling during CALC must be ignored.
        dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (lat == 3) begin
                dividend = 16'd12345; divisor = 8'd3; start = 1'b0;
            end
            if (lat == 4) start = 1'b1;
            if (done) break;
        end
        chk("midcalc_lat", lat, 9);
        chk("midcalc_q", quotient, 142);
        chk("midcalc_r", remainder, 6);
        repeat (3) @(negedge clk);
        chk("midcalc_no_relaunch", done, 1);
        chk("midcalc_hold_q", quotient, 142);
        start = 1'b0;
        @(posedge clk); @(negedge clk);

        // Asynchronous reset in the middle of CALC.
        dividend = 16'd49; divisor = 8'd7; start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'd49, 8'd7, q, r, ovf, lat, bcnt);
        chk("post_rst_q", q, 7);
        chk("post_rst_r", r, 0);
        chk("post_rst_ovf", ovf, 0);
        chk("post_rst_lat", lat, 9);

        // Randomized operands; mostly in range, with an occasional overflow case.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0]  rdv;
            logic [15:0] rdd;
            if ($urandom_range(0, 9) == 0) begin
                rdv = 8'($urandom_range(0, 255));
                rdd = {8'($urandom_range(int'(rdv), 255)), 8'($urandom)};
            end else begin
                rdv = 8'($urandom_range(1, 255));
                rdd = {8'($urandom_range(0, int'(rdv) - 1)), 8'($urandom)};
            end
            ref_div(rdd, rdv, eq, er, eovf, elat);
            run_op(rdd, rdv, q, r, ovf, lat, bcnt);
            chk($sformatf("rnd%0d_q %0d/%0d", n, rdd, rdv), q, eq);
            chk($sformatf("rnd%0d_r %0d/%0d", n, rdd, rdv), r, er);
            chk($sformatf("rnd%0d_ovf", n), ovf, eovf);
            chk($sformatf("rnd%0d_lat", n), lat, elat);
            if (!eovf) begin
                chk($sformatf("rnd%0d_identity", n),
                    longint'(q) * longint'(rdv) + longint'(r), longint'(rdd));
                chk($sformatf("rnd%0d_rem_lt_div", n), (r < rdv) ? 1 : 0, 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
